pc_redirect: RTL and testbench
==============================

// Module: pc_redirect
// PURPOSE
//  Program-counter and control-transfer resolution stage of the RV32I core.
//  Consumes the branch comparator's taken/not-taken result plus decoded jump info from execute.
//  Owns the fetch PC and drives the valid/ready fetch request to instruction memory.
//  On a taken branch/JAL/JALR: redirects fetch, emits a one-cycle flush to kill wrong-path ops.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  TRAP_VEC  32'h0000_0100  redirect target on misaligned-target trap (MISALIGN_TRAP_EN only)
// PORTS
//  clk           in   1   core clock
//  rst           in   1   asynchronous, active-high reset
//  ex_valid      in   1   execute presents a resolved op this cycle
//  ex_ready      out  1   stage can accept ex op (accept = ex_valid & ex_ready)
//  ex_is_branch  in   1   op is B-type
//  ex_is_jal     in   1   op is JAL
//  ex_is_jalr    in   1   op is JALR
//  ex_cmp_result in   1   comparator result (1 = branch condition true)
//  ex_pc         in   32  PC of the ex op
//  ex_imm        in   32  sign-extended immediate
//  ex_rs1        in   32  rs1 value (JALR base)
//  ex_link       out  32  ex_pc + 4, combinational, for rd writeback of JAL/JALR
//  if_valid      out  1   fetch request valid
//  if_ready      in   1   imem accepts request (handshake = if_valid & if_ready)
//  if_pc         out  32  fetch address, stable while if_valid & !if_ready
//  flush         out  1   kill all younger in-flight ops (one-cycle pulse)
//  trap          out  1   misaligned-target trap pulse (tied 0 without MISALIGN_TRAP_EN)
// BEHAVIOUR
//  Reset (async, rst=1): state=BOOT, if_pc=RESET_PC, if_valid=0, flush=0, trap=0, ex_ready=0.
//  FSM: BOOT -> RUN (1 cycle after rst deasserts); RUN -> FLUSH on redirect; FLUSH -> RUN always.
//  ex_ready = 1 only in RUN; if_valid = 1 only in RUN.
//  Taken = accept & (ex_is_jalr | ex_is_jal | (ex_is_branch & ex_cmp_result)).
//  Target: jalr -> (ex_rs1+ex_imm) & ~32'h1; jal/branch -> ex_pc+ex_imm. Mod 2^32, wrap silently.
//  Priority if several ex_is_* set: jalr > jal > branch.
//  Accepted non-taken op (incl. ex_valid with no ex_is_*): no effect on PC/state.
//  RUN, no redirect: on fetch handshake if_pc <= if_pc+4 (wraps 32'hFFFF_FFFC -> 0); else hold.
//  Redirect accepted in cycle N: in N+1 state=FLUSH, flush=1, if_valid=0, if_pc=target.
//   - N+2: RUN, if_valid=1, if_pc=target.
//  Redirect and fetch handshake in same cycle N: redirect wins, sequential +4 is discarded.
//   - The op fetched in N is killed by the N+1 flush.
//  Back-to-back redirects impossible: ex_ready=0 in FLUSH; execute holds ex op until accepted.
//  flush and trap are registered single-cycle pulses; never asserted in BOOT.
//  rst asserted mid-FLUSH or mid-handshake: immediately returns to reset values, no flush pulse.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: taken target with target[1]=1 -> in N+1 trap=1, flush=1,
//   if_pc=TRAP_VEC (instead of target); else identical redirect timing.
//  MISALIGN_TRAP_EN undefined: target[1:0] forced to 2'b00; trap tied 0.
// STRUCTURE
//  Shared package core_pkg: pc_state_e enum {BOOT,RUN,FLUSH}, XLEN=32, INSN_BYTES=4 constants.
//  Sub-module pc_target: combinational target/link adder (ex_pc, ex_imm, ex_rs1, is_jalr -> target, link).
//  FSM, PC register and handshake logic stay in pc_redirect.
// TESTING
//  1 Reset release, if_ready=1 -> if_valid rises 1 cycle after BOOT; if_pc 0x0,0x4,0x8 on successive cycles.
//  2 if_ready=0 for 3 cycles at if_pc=0x8 -> if_pc holds 0x8, if_valid stays 1; advances to 0xC after ready.
//  3 Branch ex_pc=0x40, ex_imm=-16, cmp=1 -> next cycle flush=1, if_valid=0, if_pc=0x30; then fetch 0x30.
//  4 Same with cmp=0 -> no flush, sequential fetch unaffected; ex_ready stays 1.
//  5 JALR rs1=0x1001, imm=0x4 -> target 0x1004, ex_link=ex_pc+4.
//  6 JAL ex_pc=0x10, imm=0x6 -> trap=1, if_pc=0x100 with macro; if_pc=0x14, trap=0 without.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core types and constants.
// Holds the PC-stage state encoding and machine-width constants.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } pc_state_e;

endpackage

// File: rtl/pc_target.sv
// Control-transfer target and link adder.
// JALR uses rs1 as base and clears bit 0; JAL/branch use the op's PC.
module pc_target
  import core_pkg::*;
(
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            is_jalr,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  assign base   = is_jalr ? ex_rs1 : ex_pc;
  assign sum    = base + ex_imm;
  assign target = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  assign link   = ex_pc + XLEN'(INSN_BYTES);

endmodule

// File: rtl/pc_redirect.sv
// PC register, fetch handshake and branch/jump redirect with flush.
// Optional MISALIGN_TRAP_EN: misaligned targets divert to TRAP_VEC with a trap pulse.
module pc_redirect
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic        ex_cmp_result,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  output logic [31:0] ex_link,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic        flush,
  output logic        trap
);

  pc_state_e   state_q;
  pc_state_e   state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        trap_q;
  logic        trap_d;
  logic [31:0] target;
  logic [31:0] aligned;
  logic [31:0] redirect_pc;
  logic        mis;
  logic        taken;

  pc_target u_target (
    .ex_pc   (ex_pc),
    .ex_imm  (ex_imm),
    .ex_rs1  (ex_rs1),
    .is_jalr (ex_is_jalr),
    .target  (target),
    .link    (ex_link)
  );

`ifdef MISALIGN_TRAP_EN
  assign mis     = target[1];
  assign aligned = target;
`else
  logic unused_lsb;
  assign unused_lsb = ^target[1:0];
  assign mis        = 1'b0;
  assign aligned    = {target[31:2], 2'b00};
`endif

  assign redirect_pc = mis ? TRAP_VEC : aligned;

  assign taken = ex_valid &
                 (ex_is_jalr | ex_is_jal |
                  (ex_is_branch & ex_cmp_result));

  assign ex_ready = (state_q == RUN);
  assign if_valid = (state_q == RUN);
  assign if_pc    = pc_q;
  assign flush    = (state_q == FLUSH);

`ifdef MISALIGN_TRAP_EN
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  // State, PC and trap-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      trap_q  <= trap_d;
    end
  end

  // Next state: redirect beats sequential fetch advance
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    trap_d  = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (taken) begin
          state_d = FLUSH;
          pc_d    = redirect_pc;
          trap_d  = mis;
        end else if (if_ready) begin
          pc_d = pc_q + 32'(INSN_BYTES);
        end
      end
      FLUSH: state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_redirect.sv
// Self-checking bench for pc_redirect.
// Directed scenarios followed by randomized ops against a reference model.
module tb_pc_redirect;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] TVEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_branch = 1'b0;
  logic        ex_is_jal = 1'b0;
  logic        ex_is_jalr = 1'b0;
  logic        ex_cmp_result = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_imm = '0;
  logic [31:0] ex_rs1 = '0;
  logic [31:0] ex_link;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic        flush;
  logic        trap;

  int errors = 0;
  int checks = 0;

  bit          m_boot = 1'b1;
  bit          m_flush = 1'b0;
  bit          m_trap = 1'b0;
  logic [31:0] m_pc = RPC;

  always #5 clk = ~clk;

  pc_redirect #(
    .RESET_PC (RPC),
    .TRAP_VEC (TVEC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_is_branch  (ex_is_branch),
    .ex_is_jal     (ex_is_jal),
    .ex_is_jalr    (ex_is_jalr),
    .ex_cmp_result (ex_cmp_result),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_rs1        (ex_rs1),
    .ex_link       (ex_link),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .flush         (flush),
    .trap          (trap)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit running;
    running = !m_boot && !m_flush;
    chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, running});
    chk({tag, ".ex_ready"}, {31'b0, ex_ready}, {31'b0, running});
    chk({tag, ".if_pc"}, if_pc, m_pc);
    chk({tag, ".flush"}, {31'b0, flush}, {31'b0, m_flush});
    chk({tag, ".trap"}, {31'b0, trap}, {31'b0, m_flush && m_trap});
  endtask

  // Where the current ex op sends fetch, from the ISA rules.
  task automatic resolve(output bit tk,
                         output logic [31:0] dest,
                         output bit mis);
    logic [31:0] t;
    tk = ex_valid && (ex_is_jalr || ex_is_jal ||
                      (ex_is_branch && ex_cmp_result));
    if (ex_is_jalr) begin
      t = ex_rs1 + ex_imm;
      if (t % 2 == 1) t = t - 1;
    end else begin
      t = ex_pc + ex_imm;
    end
`ifdef MISALIGN_TRAP_EN
    mis  = (t % 4) >= 2;
    dest = mis ? TVEC : t;
`else
    mis  = 1'b0;
    dest = t - (t % 4);
`endif
  endtask

  task automatic tick(input string tag);
    bit          tk;
    bit          mis;
    logic [31:0] dest;
    bit          nb;
    bit          nf;
    bit          nt;
    logic [31:0] np;
    resolve(tk, dest, mis);
    nb = 1'b0;
    nf = 1'b0;
    nt = 1'b0;
    np = m_pc;
    if (!m_boot && !m_flush) begin
      if (tk) begin
        nf = 1'b1;
        nt = mis;
        np = dest;
      end else if (if_ready) begin
        np = m_pc + 4;
      end
    end
    @(posedge clk);
    #1;
    m_boot  = nb;
    m_flush = nf;
    m_trap  = nt;
    m_pc    = np;
    check_all(tag);
  endtask

  task automatic set_ex(input bit v, input bit br,
                        input bit jal, input bit jalr,
                        input bit cmp, input logic [31:0] pc,
                        input logic [31:0] imm,
                        input logic [31:0] rs1);
    ex_valid      = v;
    ex_is_branch  = br;
    ex_is_jal     = jal;
    ex_is_jalr    = jalr;
    ex_cmp_result = cmp;
    ex_pc         = pc;
    ex_imm        = imm;
    ex_rs1        = rs1;
    #1;
    chk("ex_link", ex_link, pc + 32'd4);
  endtask

  task automatic idle();
    set_ex(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    tick("boot");
    chk("t1.valid", {31'b0, if_valid}, 32'd1);
    chk("t1.pc0", if_pc, 32'h0);
    tick("seq");
    chk("t1.pc4", if_pc, 32'h4);
    tick("seq");
    chk("t1.pc8", if_pc, 32'h8);

    if_ready = 1'b0;
    repeat (3) begin
      tick("stall");
      chk("t2.hold", if_pc, 32'h8);
      chk("t2.valid", {31'b0, if_valid}, 32'd1);
    end
    if_ready = 1'b1;
    tick("unstall");
    chk("t2.adv", if_pc, 32'hC);

    set_ex(1, 1, 0, 0, 1, 32'h40, -32'sd16, 32'h0);
    tick("br_taken");
    chk("t3.flush", {31'b0, flush}, 32'd1);
    chk("t3.valid", {31'b0, if_valid}, 32'd0);
    chk("t3.pc", if_pc, 32'h30);
    idle();
    tick("br_after");
    chk("t3.fetch", if_pc, 32'h30);

    set_ex(1, 1, 0, 0, 0, 32'h40, -32'sd16, 32'h0);
    tick("br_not");
    chk("t4.flush", {31'b0, flush}, 32'd0);
    chk("t4.pc", if_pc, 32'h34);
    chk("t4.ready", {31'b0, ex_ready}, 32'd1);

    set_ex(1, 0, 0, 1, 0, 32'h200, 32'h4, 32'h1001);
    chk("t5.link", ex_link, 32'h204);
    tick("jalr");
    chk("t5.pc", if_pc, 32'h1004);
    idle();
    tick("jalr_after");

    set_ex(1, 0, 1, 0, 0, 32'h10, 32'h6, 32'h0);
    tick("jal_mis");
`ifdef MISALIGN_TRAP_EN
    chk("t6.pc", if_pc, 32'h100);
    chk("t6.trap", {31'b0, trap}, 32'd1);
`else
    chk("t6.pc", if_pc, 32'h14);
    chk("t6.trap", {31'b0, trap}, 32'd0);
`endif
    idle();
    tick("jal_after");

    set_ex(1, 1, 1, 1, 1, 32'h80, 32'h8, 32'h500);
    tick("prio");
    chk("prio.pc", if_pc, 32'h508);
    idle();
    tick("prio_after");

    set_ex(1, 0, 0, 1, 0, 32'h0, 32'hC, 32'hFFFF_FFF0);
    tick("to_top");
    idle();
    tick("top_run");
    chk("wrap.top", if_pc, 32'hFFFF_FFFC);
    tick("wrap");
    chk("wrap.zero", if_pc, 32'h0);

    set_ex(1, 1, 0, 0, 1, 32'hFFFF_FFF0, 32'h20, 32'h0);
    tick("tgt_wrap");
    chk("tgt_wrap.pc", if_pc, 32'h10);
    idle();
    tick("tgt_after");

    set_ex(1, 0, 1, 0, 0, 32'h0, 32'h40, 32'h0);
    tick("pre_rst");
    idle();
    #1 rst = 1'b1;
    #1;
    m_boot  = 1'b1;
    m_flush = 1'b0;
    m_trap  = 1'b0;
    m_pc    = RPC;
    check_all("rst_mid");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
    tick("reboot");

    for (int i = 0; i < 300; i++) begin
      logic [31:0] imm;
      if ($urandom_range(0, 3) == 0) imm = $urandom;
      else imm = 32'($urandom_range(0, 255)) - 32'd128;
      set_ex($urandom_range(0, 9) < 7,
             $urandom_range(0, 9) < 3,
             $urandom_range(0, 9) < 2,
             $urandom_range(0, 9) < 2,
             $urandom_range(0, 1) == 1,
             $urandom & ~32'h3,
             imm,
             $urandom);
      if_ready = $urandom_range(0, 3) != 0;
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
